// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } rx_state_t;

endpackage

// File: rtl/uart_rx_shift.sv
// Serial-in/parallel-out register for the UART receiver.
// Shifts right, new bit enters at the MSB; clr loads all ones.
module uart_rx_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // LSB-first frames land aligned after WIDTH shifts
  always_ff @(posedge clk) begin
    if (clr)
      q <= '1;
    else if (en)
      q <= {din, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sync, start validation, bit sampling, status.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bits;
  logic                 tick;
  logic                 done;
  logic                 shift_en;
  logic                 shift_clr;
  logic [DATA_BITS-1:0] sh_q;

  // Counter reaches zero on the sample cycle of the current bit
  assign tick      = (baud == '0);
  assign done      = (state == S_STOP) && tick;
  assign shift_en  = (state == S_DATA) && tick;
  assign shift_clr = rst || ((state == S_IDLE) && !rx_s);

  // Two-flop synchroniser, idle-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_rx_shift #(
    .WIDTH (DATA_BITS)
  ) u_shift (
    .clk (clk),
    .clr (shift_clr),
    .en  (shift_en),
    .din (rx_s),
    .q   (sh_q)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  // Frame sequencer with baud and bit counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      baud  <= '0;
      bits  <= '0;
      busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            baud  <= HALF_LD;
            bits  <= '0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (!tick) begin
            baud <= baud - CW'(1);
          end else if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_DATA;
            baud  <= FULL_LD;
          end
        end
        S_DATA: begin
          if (!tick) begin
            baud <= baud - CW'(1);
          end else begin
            baud <= FULL_LD;
            if (bits == LAST)
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            else
              bits <= bits + BW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!tick) begin
            baud <= baud - CW'(1);
          end else begin
            par_bit <= rx_s;
            baud    <= FULL_LD;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!tick) begin
            baud <= baud - CW'(1);
          end else begin
            state <= rx_s ? S_IDLE : S_BREAK;
            busy  <= !rx_s;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte hand-off; a completing frame takes priority over rd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      data      <= sh_q;
      valid     <= 1'b1;
      frame_err <= ~rx_s;
      overrun   <= valid && !rd;
    end else if (rd && valid) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity over data plus parity bit, captured with the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err <= 1'b0;
    else if (done)
      parity_err <= (^sh_q) ^ par_bit;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit.
// Define UART_RX_PARITY_EN to exercise the parity frames.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = CPB / 2 + (8 + 1 + P) * CPB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   rise_cyc  = 0;
  int   start_cyc = 0;
  logic valid_d   = 1'b0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd         (rd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (valid && !valid_d) rise_cyc = cyc;
    valid_d = valid;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with rx left at stop
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (CPB) @(negedge clk);
`else
    if (par) rx = 1'b1;
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_rd;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b1, ^8'hA5);
    check("a5_lat", rise_cyc - start_cyc, LAT);
    check("a5_data", data, 8'hA5);
    check("a5_ferr", frame_err, 0);
    check("a5_busy", busy, 0);
    do_rd;

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy", busy, 1);
    repeat (20) @(negedge clk);
    check("glitch_idle", busy, 0);
    check("glitch_valid", valid, 0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    check("3c_data", data, 8'h3C);
    do_rd;

    send_frame(8'h55, 1'b0, ^8'h55);
    repeat (24) @(negedge clk);
    check("brk_data", data, 8'h55);
    check("brk_ferr", frame_err, 1);
    check("brk_busy", busy, 1);
    do_rd;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_exit", busy, 0);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    check("0f_data", data, 8'h0F);
    check("0f_ferr", frame_err, 0);
    do_rd;

    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    check("ovr_data", data, 8'h22);
    check("ovr_flag", overrun, 1);
    do_rd;
    check("ovr_valid", valid, 0);
    check("ovr_clr", overrun, 0);

    send_frame(8'h11, 1'b1, ^8'h11);
    fork
      send_frame(8'h33, 1'b1, ^8'h33);
      begin
        repeat (LAT - 1) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    check("rdwin_valid", valid, 1);
    check("rdwin_data", data, 8'h33);
    check("rdwin_ovr", overrun, 0);

    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("mid_valid", valid, 0);
    check("mid_data", data, 0);
    repeat (200) @(negedge clk);
    check("mid_spur", valid, 0);
    check("mid_busy", busy, 0);
    send_frame(8'h81, 1'b1, ^8'h81);
    check("81_valid", valid, 1);
    check("81_data", data, 8'h81);
    do_rd;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok", parity_err, 0);
    do_rd;
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad", parity_err, 1);
    do_rd;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
